// File: rtl/p1_log_pkg.sv
// Shared types and default widths for the p1 pulse logger.
package p1_log_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int W_W_DEF   = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, HIGH, DISCARD} state_t;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [W_W_DEF-1:0]  width;
  } entry_t;

endpackage

// File: rtl/p1_pulse_logger_if.sv
// Read-side valid/ready port carrying one pulse measurement {ts, width}.
interface p1_pulse_logger_if #(
  parameter int TS_W = p1_log_pkg::TS_W_DEF,
  parameter int W_W  = p1_log_pkg::W_W_DEF
);
  logic            rd_valid;
  logic            rd_ready;
  logic [TS_W-1:0] rd_ts;
  logic [W_W-1:0]  rd_width;

  modport master (output rd_valid, rd_ts, rd_width, input rd_ready);
  modport slave  (input rd_valid, rd_ts, rd_width, output rd_ready);
endinterface

// File: rtl/p1_log_fifo.sv
// FWFT FIFO: head visible the edge after push; full+push+pop accepts both; flush wins.
// Head data reads 0 while empty.
module p1_log_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wr_dat,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/p1_pulse_logger.sv
// Times each high pulse on y_in (start ts, width) and queues it; entry visible one edge after y_in falls.
// Consumer stalls via rd_ready; a full FIFO with no pop drops the entry and counts it.
module p1_pulse_logger
  import p1_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                y_in,
  input  logic                clr,
  p1_pulse_logger_if.master   rd,
  output logic                busy,
  output logic [CNT_W-1:0]    event_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                overflow
);
  state_t          state;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] start_ts;
  logic [W_W-1:0]  width;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [TS_W+W_W-1:0] head;

  assign push        = (state == HIGH) && !y_in && !clr;
  assign pop         = rd.rd_ready && !empty;
  assign busy        = (state == HIGH);
  assign rd.rd_valid = !empty;
  assign {rd.rd_ts, rd.rd_width} = head;

  p1_log_fifo #(.DEPTH(DEPTH), .DW(TS_W + W_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (rd.rd_ready),
    .flush  (clr),
    .wr_dat ({start_ts, width}),
    .rd_dat (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  // A pulse caught mid-way by clr is ignored until y_in returns low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_ts <= '0;
      width    <= '0;
    end else if (clr) begin
      state <= y_in ? DISCARD : IDLE;
    end else begin
      case (state)
        IDLE: if (y_in) begin
          start_ts <= ts;
          width    <= W_W'(1);
          state    <= HIGH;
        end
        HIGH: if (y_in) begin
          if (width != '1) width <= width + 1'b1;
        end else begin
          state <= IDLE;
        end
        DISCARD: if (!y_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (clr) begin
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (push) begin
      if (event_count != '1) event_count <= event_count + 1'b1;
      if (full && !pop) begin
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p1_pulse_logger.sv
// Randomized and directed bench for p1_pulse_logger against a pulse-list/queue reference model.
module tb_p1_pulse_logger;
  import p1_log_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       y_in = 1'b0;
  logic       clr = 1'b0;
  logic       busy;
  logic       overflow;
  logic [7:0] event_count;
  logic [7:0] drop_count;

  p1_pulse_logger_if #(.TS_W(16), .W_W(8)) rd ();

  p1_pulse_logger #(.TS_W(16), .W_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .y_in        (y_in),
    .clr         (clr),
    .rd          (rd),
    .busy        (busy),
    .event_count (event_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pulses tracked as (start, length) with an entry queue.
  entry_t      q[$];
  bit          in_pulse;
  bit          ignoring;
  logic [15:0] start_m;
  logic [15:0] ts_m;
  int          len_m;
  int          ev_m;
  int          dr_m;
  bit          ovf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic reset_model();
    q.delete();
    in_pulse = 0;
    ignoring = 0;
    start_m  = '0;
    ts_m     = '0;
    len_m    = 0;
    ev_m     = 0;
    dr_m     = 0;
    ovf_m    = 0;
  endtask

  task automatic model_edge(input bit y, input bit c, input bit r);
    bit     pop_now;
    entry_t e;
    pop_now = (q.size() != 0) && r;
    if (c) begin
      q.delete();
      ev_m = 0; dr_m = 0; ovf_m = 0;
      in_pulse = 0;
      ignoring = y;
    end else begin
      if (in_pulse && !y) begin
        e.ts    = start_m;
        e.width = (len_m > 255) ? 8'd255 : 8'(len_m);
        if (ev_m < 255) ev_m++;
        if (q.size() == DEPTH && !pop_now) begin
          if (dr_m < 255) dr_m++;
          ovf_m = 1;
        end else begin
          if (pop_now) void'(q.pop_front());
          pop_now = 0;
          q.push_back(e);
        end
        in_pulse = 0;
      end else if (in_pulse) begin
        len_m++;
      end else if (ignoring) begin
        if (!y) ignoring = 0;
      end else if (y) begin
        in_pulse = 1;
        start_m  = ts_m;
        len_m    = 1;
      end
      if (pop_now) void'(q.pop_front());
    end
    ts_m = ts_m + 16'd1;
  endtask

  task automatic compare_all();
    bit ne;
    ne = (q.size() != 0);
    check("rd_valid", 32'(rd.rd_valid), 32'(ne));
    check("rd_ts", 32'(rd.rd_ts), ne ? 32'(q[0].ts) : 32'd0);
    check("rd_width", 32'(rd.rd_width), ne ? 32'(q[0].width) : 32'd0);
    check("busy", 32'(busy), 32'(in_pulse));
    check("event_count", 32'(event_count), 32'(ev_m));
    check("drop_count", 32'(drop_count), 32'(dr_m));
    check("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(rd.rd_valid), 32'd0);
    check({tag, "_ts"}, 32'(rd.rd_ts), 32'd0);
    check({tag, "_width"}, 32'(rd.rd_width), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ev"}, 32'(event_count), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic step(input bit y, input bit c, input bit r);
    y_in = y;
    clr = c;
    rd.rd_ready = r;
    model_edge(y, c, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulses(input int n, input int hi, input bit r);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < hi; k++) step(1, 0, r);
      step(0, 0, r);
    end
  endtask

  task automatic do_reset();
    y_in = 0; clr = 0; rd.rd_ready = 0;
    rst = 1;
    #1;
    check_zero("reset");
    reset_model();
    @(posedge clk);
    #2;
    rst = 0;
  endtask

  logic [15:0] t_last;
  bit          yr;

  initial begin
    rd.rd_ready = 0;
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check_zero("idle20");

    // Single-cycle pulse sampled at ts=5.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    check("single_no_valid_yet", 32'(rd.rd_valid), 32'd0);
    step(0, 0, 0);
    check("single_valid", 32'(rd.rd_valid), 32'd1);
    check("single_ts", 32'(rd.rd_ts), 32'd5);
    check("single_width", 32'(rd.rd_width), 32'd1);
    check("single_ev", 32'(event_count), 32'd1);
    step(0, 0, 1);

    // Width 3 then a saturating 300-cycle pulse.
    pulses(1, 3, 0);
    pulses(1, 300, 0);
    check("w3_head", 32'(rd.rd_width), 32'd3);
    step(0, 0, 1);
    check("w255_head", 32'(rd.rd_width), 32'd255);
    step(0, 0, 1);
    check("drained", 32'(rd.rd_valid), 32'd0);

    // Nine pulses into an eight-deep FIFO with no reads.
    step(0, 1, 0);
    pulses(9, 1, 0);
    check("ovf9_ev", 32'(event_count), 32'd9);
    check("ovf9_drop", 32'(drop_count), 32'd1);
    check("ovf9_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    check("ovf9_drained", 32'(rd.rd_valid), 32'd0);

    // Full FIFO: pulse end coincides with a pop.
    step(0, 1, 0);
    pulses(8, 1, 0);
    t_last = ts_m;
    step(1, 0, 0);
    step(0, 0, 1);
    check("fullpop_drop", 32'(drop_count), 32'd0);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_ev", 32'(event_count), 32'd9);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    check("fullpop_last_ts", 32'(rd.rd_ts), 32'(t_last));
    step(0, 0, 1);

    // clr in the middle of a pulse.
    pulses(1, 2, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 0);
    check("clr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("discard_busy", 32'(busy), 32'd0);
    step(0, 0, 0);
    check("discard_no_entry", 32'(rd.rd_valid), 32'd0);
    check("discard_ev", 32'(event_count), 32'd0);
    pulses(1, 2, 0);
    check("after_discard_valid", 32'(rd.rd_valid), 32'd1);

    // Counter saturation.
    step(0, 1, 0);
    pulses(270, 1, 0);
    check("sat_ev", 32'(event_count), 32'd255);
    check("sat_drop", 32'(drop_count), 32'd255);
    step(0, 1, 0);

    // Random traffic.
    yr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) yr = ~yr;
      step(yr, $urandom_range(149) == 0, $urandom_range(2) != 0);
    end

    // Asynchronous reset between edges during a pulse.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    #2;
    rst = 1;
    #1;
    check_zero("async_rst");
    reset_model();
    #2;
    rst = 0;
    y_in = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/p1_pulse_logger.md
Name: p1_pulse_logger

Overview:
- Downstream consumer of the p1 Mealy detector's single-bit output Y.
- Measures every high pulse on Y: start timestamp and width in cycles.
- Queues measurements in a small first-word-fall-through (FWFT) FIFO, read through a valid/ready handshake.
- Keeps saturating event/drop counters and a sticky overflow flag for debug and status readout.

Parameters:
TS_W, 16, timestamp counter width (free-running, wraps)
W_W, 8, pulse-width field width (saturating)
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 8, width of event_count and drop_count (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
y_in  in  1  Y from the Mealy detector, synchronous to clk
clr  in  1  synchronous clear of counters/flag/FIFO
rd_ready  in  1  consumer accepts the head entry
rd_valid  out  1  FIFO non-empty; head entry presented
rd_ts  out  TS_W  head entry start timestamp
rd_width  out  W_W  head entry pulse width in cycles
busy  out  1  pulse currently being measured (FSM in HIGH)
event_count  out  CNT_W  completed pulses, including dropped ones
drop_count  out  CNT_W  pulses lost to a full FIFO
overflow  out  1  sticky: at least one drop since reset/clr

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- Reset: all registers clear immediately, with no clock edge required; FSM goes to IDLE.
  - All outputs read 0 during and after reset until an event occurs.
  - rd_ts and rd_width read 0 whenever the FIFO is empty.
- ts: free-running counter, reset 0, +1 every cycle, wraps 2^TS_W-1 -> 0. clr does not affect ts.
- FSM states: IDLE, HIGH, DISCARD. y_in is sampled on each rising edge.
  - IDLE, y_in=1: latch start_ts = current ts (value before this edge's increment); width = 1; go to HIGH.
  - HIGH, y_in=1: width += 1, saturating at 2^W_W-1; stay in HIGH.
  - HIGH, y_in=0: push {start_ts, width}; event_count += 1 (saturating); go to IDLE. A push and a new pulse start cannot coincide.
  - clr=1, any state: FSM goes to DISCARD if y_in=1, else IDLE. Any pulse in progress is abandoned with no push and no count.
  - DISCARD, y_in=0: go to IDLE. No entry is ever produced from DISCARD.
- Latency: a pulse whose last high sample is at edge N is pushed at edge N+1. rd_valid=1 after edge N+1 (FWFT, no bubble).
- Read: an entry pops at an edge where rd_valid & rd_ready. While rd_valid & !rd_ready, rd_ts and rd_width hold stable. rd_ready with an empty FIFO has no effect.
- Full FIFO:
  - Push with no pop: entry dropped; drop_count += 1 (saturating); overflow <= 1.
  - Push and pop on the same edge: both take effect, no drop.
- Empty FIFO: push and pop on the same edge is impossible, since rd_valid=0.
- clr priority: clr overrides push in the same cycle.
  - Clears event_count, drop_count, overflow.
  - Flushes the FIFO; rd_valid=0 after that edge.
- Counters hold at 2^CNT_W-1 once saturated; they do not wrap.
- busy = (state == HIGH).

Decomposition:
- Package p1_log_pkg:
  - state enum {IDLE, HIGH, DISCARD};
  - default widths TS_W/W_W/CNT_W/DEPTH;
  - entry struct {ts, width}.
- Sub-module p1_log_fifo: synchronous FWFT FIFO, parameters DEPTH and data width TS_W+W_W.
  - Ports: push, pop, flush, full, empty.
  - Pointer wrap uses an extra MSB.
- Top level holds ts, the FSM, the counters and the drop logic.

Test Plan:
- Reset, y_in=0 for 20 cycles -> rd_valid=0, busy=0, all counts 0, overflow=0.
- y_in high 1 cycle, sampled at edge where ts=5 -> one entry ts=5, width=1; rd_valid asserts one edge after y_in falls; event_count=1.
- y_in high 3 cycles, then a separate 300-cycle pulse (W_W=8) -> widths 3 and 255 in order; busy high only during the pulses.
- rd_ready=0, 9 pulses (DEPTH=8) -> 8 entries stored, drop_count=1, overflow=1, event_count=9. Drain shows the first 8 timestamps in order.
- FIFO full, pulse ends on the same edge as rd_ready=1 -> no drop, count stays 8, new entry last.
- clr mid-pulse -> no entry, counts 0, FSM in DISCARD until y_in falls. rst asserted mid-pulse between edges -> all outputs 0 immediately.
